// File: rtl/tft_cmd_uart_tx.sv
// rtl/tft_cmd_uart_tx.sv - serialises a 5-byte command frame (header, opcode, data, checksum) as 8N1 UART
module tft_cmd_uart_tx #(
  parameter int          BAUD_DIV = 868,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_data,
  input  logic        cmd_dat_update,
  output logic        cmd_ready,
  output logic        cmd_drop,
  output logic        frame_done,
  output logic        uart_tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [3:0]  opcode_q;
  logic [15:0] data_q;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;
  logic        baud_end;

  assign next_bit = bit_idx + 3'd1;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Select the frame byte currently on the wire; checksum is derived from the latched command
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = {4'h0, opcode_q};
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[7:0];
      default: cur_byte = {4'h0, opcode_q} ^ data_q[15:8] ^ data_q[7:0];
    endcase
  end

  // Frame FSM: every output, including the serial line, is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      opcode_q   <= '0;
      data_q     <= '0;
      uart_tx    <= 1'b1;
      cmd_ready  <= 1'b0;
      cmd_drop   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cmd_drop   <= cmd_dat_update & ~cmd_ready;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
          if (cmd_dat_update && cmd_ready) begin
            opcode_q  <= cmd_opcode;
            data_q    <= cmd_data;
            byte_idx  <= '0;
            bit_idx   <= '0;
            cmd_ready <= 1'b0;
            uart_tx   <= 1'b0;
            state     <= START;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= next_bit;
              uart_tx <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == 3'd4) begin
              byte_idx   <= '0;
              frame_done <= 1'b1;
              cmd_ready  <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              uart_tx  <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tft_cmd_uart_tx.md
TFT_CMD_UART_TX -- requirements
Module: tft_cmd_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 868, gives clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hA5, is the frame sync byte.
REQ-003 clk  input  1  system clock (sys_clk_100m domain).
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_opcode  input  4  command opcode, sampled on acceptance.
REQ-006 cmd_data  input  16  command payload, sampled on acceptance.
REQ-007 cmd_dat_update  input  1  one-cycle command-valid strobe.
REQ-008 cmd_ready  output  1  high when a new command can be accepted.
REQ-009 cmd_drop  output  1  one-cycle pulse when a strobe arrives while not ready.
REQ-010 frame_done  output  1  one-cycle pulse when the final stop bit completes.
REQ-011 uart_tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-012 A command shall be accepted in any cycle where cmd_dat_update=1 and cmd_ready=1; opcode and data shall be latched that cycle.
REQ-013 cmd_dat_update=1 with cmd_ready=0 shall leave the frame in progress unchanged and pulse cmd_drop the next cycle.
REQ-014 Each frame shall be 5 bytes in order: HEADER, {4'h0, opcode}, data[15:8], data[7:0], and checksum = byte1 XOR byte2 XOR byte3.
REQ-015 Each byte shall be sent as: start bit 0, data bits b0..b7, stop bit 1, with each bit held exactly BAUD_DIV cycles.
REQ-016 Bytes shall be sent back-to-back with no idle gap, so a frame lasts exactly 50*BAUD_DIV cycles.
REQ-017 The FSM shall have states IDLE, START, DATA, STOP; a 3-bit byte index (0..4) and a 3-bit bit index (0..7) shall track position in the frame.
REQ-018 In IDLE, acceptance shall move to START, and uart_tx shall go low in the cycle after acceptance.
REQ-019 START shall go to DATA, and DATA shall go to STOP after bit 7; each transition shall occur when the baud counter reaches BAUD_DIV-1.
REQ-020 STOP shall go to START with the next byte index if the index is below 4; otherwise it shall return to IDLE.
REQ-021 cmd_ready shall drop in the cycle after acceptance and shall return high in the same cycle frame_done pulses, which is the cycle after the last stop bit's final clock.
REQ-022 A strobe in the cycle where cmd_ready returns high shall be accepted, and the next start bit shall follow with zero idle bits.
REQ-023 The baud counter shall clear on every state transition and shall never exceed BAUD_DIV-1.
REQ-024 uart_tx shall be driven directly from a register, with no combinational path from inputs.

Reset
REQ-025 While rst=1, the block shall hold uart_tx=1, cmd_ready=0, cmd_drop=0, frame_done=0, state IDLE, and all counters at 0.
REQ-026 In the first cycle after rst deasserts, cmd_ready shall be 1.
REQ-027 rst asserted mid-frame shall abort the frame; uart_tx shall be 1 in the cycle after rst is sampled, and no frame_done shall be issued.
REQ-028 A strobe coincident with rst=1 shall be ignored, with no cmd_drop.

Verification (BAUD_DIV=4 unless stated)
REQ-029 Opcode 4'h3, data 16'h1234 -> line bytes A5, 03, 12, 34, 25; frame_done exactly 200 cycles after the start-bit edge; cmd_ready=0 throughout the frame.
REQ-030 Opcode 4'hF, data 16'hFFFF -> bytes A5, 0F, FF, FF, 0F; each bit measured at exactly 4 cycles.
REQ-031 A second strobe 10 cycles into a frame -> one cmd_drop pulse; first frame unchanged; only one frame_done.
REQ-032 Strobe in the frame_done cycle with opcode 1, data 0 -> second frame A5, 01, 00, 00, 01 starts the next cycle with no gap.
REQ-033 rst pulsed during byte 2 -> uart_tx=1 next cycle; no frame_done; cmd_ready=1 after release; a new frame is sent correctly.
REQ-034 BAUD_DIV=2, randomized 1000 commands with gaps, checked by a reference UART monitor -> every byte and checksum matches; drop count equals strobes issued while not ready.
